// File: rtl/game_state_rx.sv
// Receive-side deframer for the board-to-board game link: hunts for the sync byte,
// assembles a 10-byte frame, and commits it atomically only when the checksum holds.
module game_state_rx #(
   parameter logic [7:0] SYNC_BYTE    = 8'hA5,
   parameter int         BYTE_TIMEOUT = 65000,
   parameter int         LINK_TIMEOUT = 3250000
) (
   input  logic        clk65MHz,
   input  logic        rst,
   input  logic [7:0]  rx_byte,
   input  logic        rx_byte_valid,
   output logic [11:0] pl2_posx,
   output logic [11:0] pl2_posy,
   output logic [11:0] ball_xpos,
   output logic [11:0] ball_ypos,
   output logic [3:0]  score_pl1,
   output logic [3:0]  score_pl2,
   output logic        endgame,
   output logic        whistle,
   output logic        last_touch,
   output logic        frame_valid,
   output logic        frame_err,
   output logic        link_up
);

   localparam int GW = $clog2(BYTE_TIMEOUT + 1);
   localparam int LW = $clog2(LINK_TIMEOUT + 1);

   typedef enum logic [1:0] {HUNT, PAYLOAD, CHECK} state_t;

   state_t          state;
   state_t          state_next;
   logic [3:0]      idx;
   logic [7:0]      run_xor;
   logic [7:0][7:0] shadow;
   logic [GW-1:0]   gap_cnt;
   logic [LW-1:0]   link_cnt;
   logic            timeout;
   logic            frame_ok;
   logic            commit;
   logic            reject;

   // An arriving byte always wins over a timeout that would fire in the same cycle.
   assign timeout  = (state != HUNT) && !rx_byte_valid && (gap_cnt == GW'(BYTE_TIMEOUT - 1));
   assign frame_ok = (rx_byte == run_xor) && (shadow[7][7:3] == 5'd0);

   always_ff @(posedge clk65MHz) begin
      if (rst) begin
         state <= HUNT;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         HUNT: begin
            if (rx_byte_valid && rx_byte == SYNC_BYTE) begin
               state_next = PAYLOAD;
            end
         end
         PAYLOAD: begin
            if (timeout) begin
               state_next = HUNT;
            end else if (rx_byte_valid && idx == 4'd8) begin
               state_next = CHECK;
            end
         end
         CHECK: begin
            if (timeout || rx_byte_valid) begin
               state_next = HUNT;
            end
         end
         default: state_next = HUNT;
      endcase
   end

   always_comb begin
      commit = 1'b0;
      reject = 1'b0;
      if (state == CHECK && rx_byte_valid) begin
         if (frame_ok) begin
            commit = 1'b1;
         end else begin
            reject = 1'b1;
         end
      end
      if (timeout) begin
         reject = 1'b1;
      end
   end

   // Shadow bytes shift in so that after b8 shadow[0] holds b1 and shadow[7] holds b8.
   always_ff @(posedge clk65MHz) begin
      if (rst) begin
         idx     <= '0;
         run_xor <= '0;
         shadow  <= '0;
         gap_cnt <= '0;
      end else begin
         if (rx_byte_valid || state == HUNT) begin
            gap_cnt <= '0;
         end else begin
            gap_cnt <= gap_cnt + GW'(1);
         end
         if (state == HUNT && rx_byte_valid && rx_byte == SYNC_BYTE) begin
            idx     <= 4'd1;
            run_xor <= '0;
         end else if (state == PAYLOAD && rx_byte_valid) begin
            shadow  <= {rx_byte, shadow[7:1]};
            run_xor <= run_xor ^ rx_byte;
            idx     <= idx + 4'd1;
         end
      end
   end

   always_ff @(posedge clk65MHz) begin
      if (rst) begin
         pl2_posx    <= '0;
         pl2_posy    <= '0;
         ball_xpos   <= '0;
         ball_ypos   <= '0;
         score_pl1   <= '0;
         score_pl2   <= '0;
         endgame     <= 1'b0;
         whistle     <= 1'b0;
         last_touch  <= 1'b0;
         frame_valid <= 1'b0;
         frame_err   <= 1'b0;
      end else begin
         frame_valid <= commit;
         frame_err   <= reject;
         if (commit) begin
            pl2_posx   <= {shadow[0], shadow[1][7:4]};
            pl2_posy   <= {shadow[1][3:0], shadow[2]};
            ball_xpos  <= {shadow[3], shadow[4][7:4]};
            ball_ypos  <= {shadow[4][3:0], shadow[5]};
            score_pl1  <= shadow[6][7:4];
            score_pl2  <= shadow[6][3:0];
            endgame    <= shadow[7][2];
            whistle    <= shadow[7][1];
            last_touch <= shadow[7][0];
         end
      end
   end

   // link_up drops in the cycle the counter lands on LINK_TIMEOUT after the last commit.
   always_ff @(posedge clk65MHz) begin
      if (rst) begin
         link_cnt <= '0;
         link_up  <= 1'b0;
      end else if (commit) begin
         link_cnt <= '0;
         link_up  <= 1'b1;
      end else begin
         if (link_cnt != LW'(LINK_TIMEOUT)) begin
            link_cnt <= link_cnt + LW'(1);
         end
         if (link_cnt == LW'(LINK_TIMEOUT - 1)) begin
            link_up <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_game_state_rx.sv
// Bench for game_state_rx: directed frames with literal expectations, then random
// traffic compared every cycle against a queue-based frame model.
module tb_game_state_rx;

   localparam logic [7:0] SYNC = 8'hA5;
   localparam int         BT   = 100;
   localparam int         LT   = 1000;

   typedef logic [0:9][7:0] frame_t;

   logic        clk65MHz = 1'b0;
   logic        rst;
   logic [7:0]  rx_byte;
   logic        rx_byte_valid;
   logic [11:0] pl2_posx, pl2_posy, ball_xpos, ball_ypos;
   logic [3:0]  score_pl1, score_pl2;
   logic        endgame, whistle, last_touch, frame_valid, frame_err, link_up;

   int assert_count = 0;
   int fail_count   = 0;
   int fv_count     = 0;
   int fe_count     = 0;
   bit check_en     = 1'b0;

   logic [7:0]  frm[$];
   int          idle       = 0;
   longint      cyc        = 0;
   longint      commit_cyc = 0;
   bit          linked     = 1'b0;
   logic [11:0] exp_posx = '0, exp_posy = '0, exp_ballx = '0, exp_bally = '0;
   logic [3:0]  exp_s1 = '0, exp_s2 = '0;
   logic        exp_end = 1'b0, exp_whistle = 1'b0, exp_last = 1'b0;
   logic        exp_fv = 1'b0, exp_fe = 1'b0, exp_link = 1'b0;

   always #5 clk65MHz = ~clk65MHz;

   game_state_rx #(
      .SYNC_BYTE   (SYNC),
      .BYTE_TIMEOUT(BT),
      .LINK_TIMEOUT(LT)
   ) dut (
      .clk65MHz     (clk65MHz),
      .rst          (rst),
      .rx_byte      (rx_byte),
      .rx_byte_valid(rx_byte_valid),
      .pl2_posx     (pl2_posx),
      .pl2_posy     (pl2_posy),
      .ball_xpos    (ball_xpos),
      .ball_ypos    (ball_ypos),
      .score_pl1    (score_pl1),
      .score_pl2    (score_pl2),
      .endgame      (endgame),
      .whistle      (whistle),
      .last_touch   (last_touch),
      .frame_valid  (frame_valid),
      .frame_err    (frame_err),
      .link_up      (link_up)
   );

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      assert_count++;
      if (act !== exp) begin
         fail_count++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input logic [7:0] b, input int idle_before);
      rx_byte_valid = 1'b0;
      repeat (idle_before) begin
         @(posedge clk65MHz);
         #1;
      end
      rx_byte       = b;
      rx_byte_valid = 1'b1;
      @(posedge clk65MHz);
      #1;
      rx_byte_valid = 1'b0;
   endtask

   task automatic idleCycles(input int n);
      repeat (n) begin
         @(posedge clk65MHz);
         #1;
      end
   endtask

   task automatic sendFrame(input frame_t fr);
      for (int i = 0; i < 10; i++) applyStimulus(fr[i], 0);
   endtask

   task automatic pulseReset();
      rst = 1'b1;
      @(posedge clk65MHz);
      #1;
      rst = 1'b0;
   endtask

   function automatic frame_t makeFrame(input logic [11:0] px, input logic [11:0] py,
                                        input logic [11:0] bx, input logic [11:0] by,
                                        input logic [3:0] s1, input logic [3:0] s2,
                                        input logic [7:0] fl);
      frame_t f;
      f[0] = SYNC;
      f[1] = px[11:4];
      f[2] = {px[3:0], py[11:8]};
      f[3] = py[7:0];
      f[4] = bx[11:4];
      f[5] = {bx[3:0], by[11:8]};
      f[6] = by[7:0];
      f[7] = {s1, s2};
      f[8] = fl;
      f[9] = 8'h00;
      for (int i = 1; i <= 8; i++) f[9] ^= f[i];
      return f;
   endfunction

   // Reference: a frame is whatever follows a sync byte while the collected list is empty.
   always @(posedge clk65MHz) begin : model
      frame_t     b;
      logic [7:0] x;
      cyc++;
      exp_fv = 1'b0;
      exp_fe = 1'b0;
      if (rst) begin
         frm.delete();
         idle      = 0;
         linked    = 1'b0;
         exp_posx  = '0; exp_posy = '0; exp_ballx = '0; exp_bally = '0;
         exp_s1    = '0; exp_s2 = '0;
         exp_end   = 1'b0; exp_whistle = 1'b0; exp_last = 1'b0;
         exp_link  = 1'b0;
      end else begin
         if (rx_byte_valid) begin
            idle = 0;
            if (frm.size() != 0 || rx_byte == SYNC) frm.push_back(rx_byte);
            if (frm.size() == 10) begin
               for (int i = 0; i < 10; i++) b[i] = frm[i];
               x = 8'h00;
               for (int i = 1; i <= 8; i++) x ^= b[i];
               if (x == b[9] && b[8][7:3] == 5'd0) begin
                  exp_fv      = 1'b1;
                  exp_posx    = {b[1], b[2][7:4]};
                  exp_posy    = {b[2][3:0], b[3]};
                  exp_ballx   = {b[4], b[5][7:4]};
                  exp_bally   = {b[5][3:0], b[6]};
                  exp_s1      = b[7][7:4];
                  exp_s2      = b[7][3:0];
                  exp_end     = b[8][2];
                  exp_whistle = b[8][1];
                  exp_last    = b[8][0];
                  linked      = 1'b1;
                  commit_cyc  = cyc;
               end else begin
                  exp_fe = 1'b1;
               end
               frm.delete();
            end
         end else if (frm.size() != 0) begin
            idle++;
            if (idle == BT) begin
               exp_fe = 1'b1;
               frm.delete();
               idle = 0;
            end
         end
         exp_link = linked && ((cyc - commit_cyc) < LT);
      end
   end

   always @(negedge clk65MHz) begin
      if (frame_valid === 1'b1) fv_count++;
      if (frame_err === 1'b1) fe_count++;
      if (check_en) begin
         checkOutput("pl2_posx",    32'(pl2_posx),    32'(exp_posx));
         checkOutput("pl2_posy",    32'(pl2_posy),    32'(exp_posy));
         checkOutput("ball_xpos",   32'(ball_xpos),   32'(exp_ballx));
         checkOutput("ball_ypos",   32'(ball_ypos),   32'(exp_bally));
         checkOutput("score_pl1",   32'(score_pl1),   32'(exp_s1));
         checkOutput("score_pl2",   32'(score_pl2),   32'(exp_s2));
         checkOutput("endgame",     32'(endgame),     32'(exp_end));
         checkOutput("whistle",     32'(whistle),     32'(exp_whistle));
         checkOutput("last_touch",  32'(last_touch),  32'(exp_last));
         checkOutput("frame_valid", 32'(frame_valid), 32'(exp_fv));
         checkOutput("frame_err",   32'(frame_err),   32'(exp_fe));
         checkOutput("link_up",     32'(link_up),     32'(exp_link));
      end
   end

   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      frame_t fr1, fr2, fr;
      int     base_fv, base_fe, n, kind, pos;
      logic [7:0] g;

      rst           = 1'b1;
      rx_byte       = 8'h00;
      rx_byte_valid = 1'b0;
      idleCycles(3);
      rst      = 1'b0;
      check_en = 1'b1;

      checkOutput("reset_posx",  32'(pl2_posx),    32'h0);
      checkOutput("reset_score", 32'(score_pl2),   32'h0);
      checkOutput("reset_link",  32'(link_up),     32'h0);
      checkOutput("reset_fv",    32'(frame_valid), 32'h0);

      fr1 = 80'hA5_12_34_56_78_90_AB_37_03_07;
      sendFrame(fr1);
      checkOutput("valid_fv",     32'(frame_valid), 32'h1);
      checkOutput("valid_posx",   32'(pl2_posx),    32'h123);
      checkOutput("valid_posy",   32'(pl2_posy),    32'h456);
      checkOutput("valid_ballx",  32'(ball_xpos),   32'h789);
      checkOutput("valid_bally",  32'(ball_ypos),   32'h0AB);
      checkOutput("valid_scores", 32'({score_pl1, score_pl2}), 32'h37);
      checkOutput("valid_flags",  32'({endgame, whistle, last_touch}), 32'h3);
      checkOutput("valid_link",   32'(link_up),     32'h1);

      fr    = fr1;
      fr[9] = 8'h08;
      sendFrame(fr);
      checkOutput("badsum_fe",   32'(frame_err),   32'h1);
      checkOutput("badsum_fv",   32'(frame_valid), 32'h0);
      checkOutput("badsum_posx", 32'(pl2_posx),    32'h123);

      fr    = fr1;
      fr[8] = 8'h83;
      fr[9] = 8'h87;
      sendFrame(fr);
      checkOutput("reserved_fe",    32'(frame_err), 32'h1);
      checkOutput("reserved_ballx", 32'(ball_xpos), 32'h789);

      fr2     = makeFrame(12'hABC, 12'hDEF, 12'h012, 12'h345, 4'h9, 4'h2, 8'h04);
      base_fv = fv_count;
      applyStimulus(8'h00, 0);
      applyStimulus(8'hFF, 0);
      applyStimulus(8'h5A, 0);
      sendFrame(fr1);
      sendFrame(fr2);
      idleCycles(2);
      checkOutput("b2b_pulses", 32'(fv_count - base_fv), 32'd2);
      checkOutput("b2b_posx",   32'(pl2_posx),  32'hABC);
      checkOutput("b2b_bally",  32'(ball_ypos), 32'h345);
      checkOutput("b2b_flags",  32'({endgame, whistle, last_touch}), 32'h4);

      base_fe = fe_count;
      applyStimulus(SYNC, 0);
      applyStimulus(8'h12, 0);
      applyStimulus(8'h34, 0);
      idleCycles(102);
      checkOutput("timeout_fe", 32'(fe_count - base_fe), 32'd1);
      sendFrame(fr1);
      checkOutput("after_timeout_fv",   32'(frame_valid), 32'h1);
      checkOutput("after_timeout_posx", 32'(pl2_posx),    32'h123);

      base_fe = fe_count;
      for (int i = 0; i < 10; i++) applyStimulus(fr2[i], (i == 3) ? 99 : 0);
      checkOutput("gap99_fv",   32'(frame_valid), 32'h1);
      checkOutput("gap99_posx", 32'(pl2_posx),    32'hABC);
      idleCycles(2);
      checkOutput("gap99_noerr", 32'(fe_count - base_fe), 32'd0);

      sendFrame(fr1);
      n = 0;
      while (link_up === 1'b1 && n < 1100) begin
         @(posedge clk65MHz);
         #1;
         n++;
      end
      checkOutput("link_timeout_cycles", 32'(n), 32'd1000);

      sendFrame(fr2);
      base_fe = fe_count;
      for (int i = 0; i < 5; i++) applyStimulus(fr1[i], 0);
      pulseReset();
      checkOutput("rst_posx",  32'(pl2_posx),  32'h0);
      checkOutput("rst_score", 32'(score_pl1), 32'h0);
      checkOutput("rst_link",  32'(link_up),   32'h0);
      idleCycles(3);
      checkOutput("rst_noerr", 32'(fe_count - base_fe), 32'd0);
      sendFrame(fr2);
      checkOutput("rst_next_fv",   32'(frame_valid), 32'h1);
      checkOutput("rst_next_posx", 32'(pl2_posx),    32'hABC);

      for (int k = 0; k < 250; k++) begin
         kind = $urandom_range(0, 19);
         fr = makeFrame(12'($urandom), 12'($urandom), 12'($urandom), 12'($urandom),
                        4'($urandom), 4'($urandom),
                        (kind == 1) ? 8'($urandom) : {5'b0, 3'($urandom)});
         if (kind == 2) fr[9] ^= 8'(1 << $urandom_range(0, 7));
         if (kind == 6) fr[1 + $urandom_range(0, 6)] = SYNC;
         repeat ($urandom_range(0, 2)) begin
            g = 8'($urandom);
            if (g == SYNC) g = 8'h00;
            applyStimulus(g, $urandom_range(0, 3));
         end
         pos = $urandom_range(1, 9);
         for (int i = 0; i < 10; i++) begin
            if (kind == 4 && i == pos) pulseReset();
            if (kind == 5 && i == pos) begin
               idleCycles(BT + 3);
               break;
            end
            applyStimulus(fr[i], (kind == 3 && i == pos) ? $urandom_range(BT - 3, BT + 2)
                                                         : $urandom_range(0, 2));
         end
      end
      idleCycles(5);

      $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
      $finish;
   end

endmodule
